// File: rtl/mr_run_ctrl_pkg.sv
// Shared state encoding and default timing constants for the CPU run controller.
package mr_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } run_state_t;

  localparam int         DEF_RESET_CYCLES = 6;
  localparam logic [7:0] DEF_WDOG_LIMIT   = 8'd200;

endpackage

// File: rtl/mr_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module mr_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_1hz,
  input  logic         RST,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] ONE     = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_1hz) begin
    if (RST || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX_VAL)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mr_run_ctrl.sv
// Run/step/halt sequencer for the CPU core: reset hold-off, clock enable, output capture and a
// stall watchdog that parks the core when its output port stops changing while free-running.
module mr_run_ctrl
  import mr_run_ctrl_pkg::*;
#(
  parameter int         RESET_CYCLES = DEF_RESET_CYCLES,
  parameter logic [7:0] WDOG_LIMIT   = DEF_WDOG_LIMIT
) (
  input  logic        clk_1hz,
  input  logic        RST,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        reset_req,
  input  logic [15:0] cpu_out,
  input  logic        cpu_halt,
  output logic        cpu_rst,
  output logic        cpu_ce,
  output logic [15:0] disp,
  output logic [2:0]  state,
  output logic        fault,
  output logic [15:0] ce_count
);

  localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);

  run_state_t  r_state;
  run_state_t  w_next;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  r_wdog;
  logic [15:0] r_prev_out;
  logic [15:0] r_disp;
  logic        r_fault;
  logic        w_cpu_rst;
  logic        w_cpu_ce;
  logic        w_wdog_trip;

  // A CPU halt in the same cycle outranks the watchdog, so no fault is flagged then.
  assign w_wdog_trip = (r_state == ST_RUN) && !cpu_halt && (r_wdog == WDOG_LIMIT);

  always_ff @(posedge clk_1hz) begin
    if (RST) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (reset_req) begin
      w_next = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD:   if (r_hold_cnt == HOLD_LAST) w_next = ST_IDLE;
        ST_IDLE: begin
          if (step_req)     w_next = ST_STEP;
          else if (run_req) w_next = ST_RUN;
        end
        ST_STEP:   w_next = cpu_halt ? ST_HALTED : ST_IDLE;
        ST_RUN: begin
          if (cpu_halt || w_wdog_trip) w_next = ST_HALTED;
          else if (halt_req)           w_next = ST_IDLE;
        end
        ST_HALTED: w_next = ST_HALTED;
        default:   w_next = ST_HOLD;
      endcase
    end
  end

  always_comb begin
    w_cpu_rst = 1'b0;
    w_cpu_ce  = 1'b0;
    case (r_state)
      ST_HOLD:         w_cpu_rst = 1'b1;
      ST_RUN, ST_STEP: w_cpu_ce  = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clk_1hz) begin
    if (RST) begin
      r_prev_out <= '0;
    end else begin
      r_prev_out <= cpu_out;
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (RST || reset_req) begin
      r_hold_cnt <= '0;
      r_wdog     <= '0;
      r_fault    <= 1'b0;
      r_disp     <= '0;
    end else begin
      r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + 8'd1 : 8'd0;
      if ((r_state == ST_RUN) && (w_next == ST_RUN)) begin
        r_wdog <= (cpu_out != r_prev_out) ? 8'd0 : r_wdog + 8'd1;
      end else begin
        r_wdog <= '0;
      end
      if (w_wdog_trip) r_fault <= 1'b1;
      if (w_cpu_ce)    r_disp  <= cpu_out;
    end
  end

  mr_sat_counter #(
    .W(16)
  ) u_ce_count (
    .clk_1hz (clk_1hz),
    .RST     (RST),
    .i_clr   (reset_req),
    .i_en    (w_cpu_ce),
    .o_count (ce_count)
  );

  assign cpu_rst = w_cpu_rst;
  assign cpu_ce  = w_cpu_ce;
  assign disp    = r_disp;
  assign state   = r_state;
  assign fault   = r_fault;

endmodule

// File: tb/tb_mr_run_ctrl.sv
// Bench for mr_run_ctrl: directed scenarios plus random pulses, checked every cycle against a reference model.
module tb_mr_run_ctrl;

  localparam int RC    = 6;
  localparam int WL    = 200;
  localparam int EXP_W = 42;

  // clock / reset
  logic clk_1hz = 1'b0;
  logic RST     = 1'b1;
  always #5 clk_1hz = ~clk_1hz;

  logic        run_req = 0, step_req = 0, halt_req = 0, reset_req = 0;
  logic [15:0] cpu_out = '0;
  logic        cpu_halt = 0;
  logic        cpu_rst, cpu_ce, fault;
  logic [15:0] disp, ce_count;
  logic [2:0]  state;
  logic        s_en = 0, s_clr = 0;
  logic [3:0]  s_cnt;

  mr_run_ctrl dut (
    .clk_1hz(clk_1hz), .RST(RST), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .reset_req(reset_req), .cpu_out(cpu_out), .cpu_halt(cpu_halt),
    .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .disp(disp), .state(state), .fault(fault),
    .ce_count(ce_count)
  );

  mr_sat_counter #(.W(4)) u_sat4 (
    .clk_1hz(clk_1hz), .RST(RST), .i_clr(s_clr), .i_en(s_en), .o_count(s_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // reference model: states 0=HOLD 1=IDLE 2=RUN 3=STEP 4=HALTED
  int          m_state = 0, m_hold = 0, m_wd = 0, m_cnt = 0, m_s4 = 0;
  logic [15:0] m_prev = '0, m_disp = '0;
  bit          m_fault = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic model_step();
    int nxt;
    bit ce;
    if (RST) begin
      m_state = 0; m_hold = 0; m_wd = 0; m_disp = '0; m_fault = 0; m_cnt = 0; m_prev = '0;
    end else begin
      ce  = (m_state == 2) || (m_state == 3);
      nxt = m_state;
      if (reset_req) begin
        nxt = 0; m_hold = 0; m_wd = 0; m_disp = '0; m_fault = 0; m_cnt = 0;
      end else begin
        if (ce) begin
          m_disp = cpu_out;
          if (m_cnt < 65535) m_cnt++;
        end
        case (m_state)
          0: if (m_hold == RC - 1) begin nxt = 1; m_hold = 0; end else m_hold++;
          1: if (step_req) nxt = 3; else if (run_req) nxt = 2;
          2: begin
            if (cpu_halt) nxt = 4;
            else if (m_wd == WL) begin nxt = 4; m_fault = 1; end
            else if (halt_req) nxt = 1;
            else m_wd = (cpu_out != m_prev) ? 0 : m_wd + 1;
          end
          3: nxt = cpu_halt ? 4 : 1;
          default: ;
        endcase
        if (nxt != 2) m_wd = 0;
      end
      m_state = nxt;
      m_prev  = cpu_out;
    end
    if (RST || s_clr) m_s4 = 0;
    else if (s_en && m_s4 < 15) m_s4++;
    exp_q.push_back({3'(m_state), m_state == 0, (m_state == 2) || (m_state == 3), m_fault,
                     m_disp, 16'(m_cnt), 4'(m_s4)});
  endtask

  task automatic check_all();
    logic [EXP_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 32'(state), 32'(e[41:39]));
      chk("cpu_rst", 32'(cpu_rst), 32'(e[38]));
      chk("cpu_ce", 32'(cpu_ce), 32'(e[37]));
      chk("fault", 32'(fault), 32'(e[36]));
      chk("disp", 32'(disp), 32'(e[35:20]));
      chk("ce_count", 32'(ce_count), 32'(e[19:4]));
      chk("sat4", 32'(s_cnt), 32'(e[3:0]));
    end
  endtask

  // driver: inputs are set at the falling edge, sampled by DUT and model at the rising edge
  task automatic step_cycle();
    @(posedge clk_1hz);
    model_step();
    @(negedge clk_1hz);
    cyc++;
    check_all();
    run_req = 0; step_req = 0; halt_req = 0; reset_req = 0; s_clr = 0;
  endtask

  task automatic soft_reset();
    reset_req = 1;
    step_cycle();
    repeat (RC) step_cycle();
    chk("sr_idle", 32'(state), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    // power-on reset and hold-off
    repeat (3) step_cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    RST = 0;
    repeat (RC - 1) step_cycle();
    chk("hold_last_rst", 32'(cpu_rst), 32'd1);
    step_cycle();
    chk("hold_done_state", 32'(state), 32'd1);
    chk("hold_done_ce", 32'(cpu_ce), 32'd0);

    // single step
    cpu_out = 16'h00A5; step_req = 1; run_req = 1;
    step_cycle();
    chk("step_ce", 32'(cpu_ce), 32'd1);
    step_cycle();
    chk("step_disp", 32'(disp), 32'h00A5);
    chk("step_cnt", 32'(ce_count), 32'd1);
    chk("step_back_idle", 32'(state), 32'd1);

    // free run then CPU halt
    soft_reset();
    cpu_out = 16'h0100; run_req = 1;
    step_cycle();
    for (int i = 0; i < 10; i++) begin
      cpu_out = 16'h0101 + 16'(i);
      step_cycle();
    end
    cpu_out = 16'h0200; cpu_halt = 1;
    step_cycle();
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_ce", 32'(cpu_ce), 32'd0);
    chk("halt_cnt", 32'(ce_count), 32'd11);
    chk("halt_fault", 32'(fault), 32'd0);
    cpu_halt = 0; run_req = 1; step_req = 1;
    step_cycle();
    chk("halted_sticky", 32'(state), 32'd4);

    // watchdog expiry
    cpu_out = 16'h1234;
    soft_reset();
    run_req = 1;
    step_cycle();
    k = 0;
    while (state != 3'd4 && k < 400) begin
      step_cycle();
      k++;
    end
    chk("wdog_cycles", 32'(k), 32'd201);
    chk("wdog_fault", 32'(fault), 32'd1);
    chk("wdog_cnt", 32'(ce_count), 32'd201);
    reset_req = 1;
    step_cycle();
    chk("sr_fault_clr", 32'(fault), 32'd0);
    chk("sr_disp_clr", 32'(disp), 32'd0);
    chk("sr_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (RC) step_cycle();
    chk("sr_hold_len", 32'(state), 32'd1);

    // halt_req and cpu_halt together, then reset_req mid-hold
    run_req = 1;
    step_cycle();
    cpu_out = 16'h0001; step_cycle();
    cpu_out = 16'h0002; halt_req = 1; cpu_halt = 1;
    step_cycle();
    chk("halt_prio", 32'(state), 32'd4);
    cpu_halt = 0; reset_req = 1;
    step_cycle();
    repeat (3) step_cycle();
    reset_req = 1;
    step_cycle();
    repeat (RC - 1) step_cycle();
    chk("rehold_rst", 32'(cpu_rst), 32'd1);
    step_cycle();
    chk("rehold_done", 32'(state), 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      RST       = ($urandom_range(0, 299) == 0);
      reset_req = ($urandom_range(0, 99) == 0);
      run_req   = ($urandom_range(0, 9) == 0);
      step_req  = ($urandom_range(0, 9) == 0);
      halt_req  = ($urandom_range(0, 11) == 0);
      cpu_halt  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) cpu_out = 16'($urandom_range(0, 3));
      s_en  = ($urandom_range(0, 3) != 0);
      s_clr = ($urandom_range(0, 39) == 0);
      step_cycle();
    end
    RST = 0; cpu_halt = 0;

    // saturation boundary on the small counter
    s_clr = 1; step_cycle();
    s_en = 1;
    repeat (20) step_cycle();
    chk("sat4_top", 32'(s_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
